// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared state encoding, Hi/Lo select codes and default watchdog limit
package muldiv_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MULT_RUN = 3'd1,
    S_DIV_RUN  = 3'd2,
    S_WB       = 3'd3,
    S_EXC      = 3'd4,
    S_TMO      = 3'd5
  } state_t;
  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;
  localparam int TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/muldiv_run_counter.sv
// muldiv_run_counter: saturating run-cycle counter with clear, enable and limit compare
// Ports: clk, reset (async active-low), i_clr, i_en -> o_cnt (saturating count), o_at_limit (count == LIMIT-1)
module muldiv_run_counter #(
  parameter int CNT_W = 7,
  parameter int LIMIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_limit
);
  assign o_at_limit = o_cnt == CNT_W'(LIMIT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) o_cnt <= '0;
    else if (i_clr) o_cnt <= '0;
    else if (i_en && o_cnt != '1) o_cnt <= o_cnt + 1'b1;
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the shared multiplier/divider on behalf of the multicycle control unit
// Inputs : clk, reset (async active-low), start_mult, start_div, mult_stop, div_stop, div_zero
// Outputs: mult_control, div_control, HiLo_load, sel_mux_hi, sel_mux_lo, busy, done,
//          dp0_exc, req_err, timeout_err, run_cycles (all registered)
// Option : MULDIV_TIMEOUT_EN enables the TIMEOUT_CYCLES watchdog; otherwise a run waits forever
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             mult_stop,
  input  logic             div_stop,
  input  logic             div_zero,
  output logic             mult_control,
  output logic             div_control,
  output logic             HiLo_load,
  output logic             sel_mux_hi,
  output logic             sel_mux_lo,
  output logic             busy,
  output logic             done,
  output logic             dp0_exc,
  output logic             req_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] run_cycles
);
  state_t r_state, w_next;
  logic w_start, w_idle, w_run, w_at_limit, w_tmo, w_mult_fin, w_div_fin;
  assign w_start = start_mult | start_div;
  assign w_idle  = r_state == S_IDLE;
  assign w_run   = r_state == S_MULT_RUN || r_state == S_DIV_RUN;
  // the control pulse is high exactly in the first RUN cycle, where stop flags are not trusted yet
  assign w_mult_fin = mult_stop & ~mult_control;
  assign w_div_fin  = div_stop & ~div_control;
`ifdef MULDIV_TIMEOUT_EN
  assign w_tmo = w_at_limit;
`else
  logic w_unused_limit;
  assign w_unused_limit = w_at_limit;
  assign w_tmo = 1'b0;
`endif
  muldiv_run_counter #(.CNT_W(CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_idle & w_start),
    .i_en      (w_run),
    .o_cnt     (run_cycles),
    .o_at_limit(w_at_limit)
  );
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:     w_next = start_mult ? S_MULT_RUN : start_div ? S_DIV_RUN : S_IDLE;
      S_MULT_RUN: w_next = w_mult_fin ? S_WB : w_tmo ? S_TMO : S_MULT_RUN;
      S_DIV_RUN:  w_next = div_zero ? S_EXC : w_div_fin ? S_WB : w_tmo ? S_TMO : S_DIV_RUN;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state      <= S_IDLE;
      mult_control <= 1'b0;
      div_control  <= 1'b0;
      HiLo_load    <= 1'b0;
      sel_mux_hi   <= 1'b0;
      sel_mux_lo   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dp0_exc      <= 1'b0;
      req_err      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      r_state      <= w_next;
      mult_control <= w_idle & start_mult;
      div_control  <= w_idle & ~start_mult & start_div;
      if (w_idle && w_start) begin
        sel_mux_hi <= start_mult ? SEL_MULT : SEL_DIV;
        sel_mux_lo <= start_mult ? SEL_MULT : SEL_DIV;
      end
      busy         <= w_next != S_IDLE;
      HiLo_load    <= w_next == S_WB;
      done         <= w_next == S_WB;
      dp0_exc      <= w_next == S_EXC;
      timeout_err  <= w_next == S_TMO;
      // simultaneous requests in IDLE lose the DIV; any request outside IDLE is dropped
      req_err      <= w_idle ? start_mult & start_div : w_start;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of muldiv_sequencer against an arithmetic timeline model
module tb_muldiv_sequencer;
`ifdef MULDIV_TIMEOUT_EN
  localparam int SMAX = 7;
`else
  localparam int SMAX = 40;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic start_mult = 0, start_div = 0, mult_stop = 0, div_stop = 0, div_zero = 0;
  logic mult_control, div_control, HiLo_load, sel_mux_hi, sel_mux_lo, busy, done;
  logic dp0_exc, req_err, timeout_err;
  logic [6:0] run_cycles;
  int n_checks = 0, n_err = 0;

  muldiv_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .mult_stop(mult_stop), .div_stop(div_stop), .div_zero(div_zero),
    .mult_control(mult_control), .div_control(div_control), .HiLo_load(HiLo_load),
    .sel_mux_hi(sel_mux_hi), .sel_mux_lo(sel_mux_lo), .busy(busy), .done(done),
    .dp0_exc(dp0_exc), .req_err(req_err), .timeout_err(timeout_err), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " outputs"}, {mult_control, div_control, HiLo_load, sel_mux_hi, sel_mux_lo,
                            busy, done, dp0_exc, req_err, timeout_err}, 0);
  endtask

  // Cycle 0 presents the request; cycle 1 is the first RUN cycle. The operation ends in
  // cycle e (stop in cycle s, or zero in cycle z), its WB/EXC cycle is f=e+1, busy spans 1..f,
  // and run_cycles reads k-1 during the run, then freezes at e.
  task automatic run_op(input bit is_div, input int s, input int z, input bit both, input int junk);
    int f;
    f = (z > 0 ? z : s) + 1;
    for (int k = 0; k <= f + 1; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("mult_control", mult_control, !is_div && k == 1);
        chk("div_control", div_control, is_div && k == 1);
        chk("busy", busy, k <= f);
        chk("HiLo_load", HiLo_load, k == f && z == 0);
        chk("done", done, k == f && z == 0);
        chk("dp0_exc", dp0_exc, k == f && z > 0);
        chk("sel_mux_hi", sel_mux_hi, is_div);
        chk("sel_mux_lo", sel_mux_lo, is_div);
        chk("req_err", req_err, (both && k == 1) || (junk > 0 && k == junk + 1));
        chk("timeout_err", timeout_err, 0);
        chk("run_cycles", run_cycles, k <= f ? k - 1 : f - 1);
      end
      start_mult = (k == 0 && (!is_div || both)) || (junk > 0 && k == junk && is_div);
      start_div  = (k == 0 && (is_div || both)) || (junk > 0 && k == junk && !is_div);
      mult_stop  = is_div ? 1'($urandom % 2) : (k == s || (k == 1 && 1'($urandom % 2)));
      div_stop   = !is_div ? 1'($urandom % 2) : (k == s || (k == 1 && 1'($urandom % 2)));
      div_zero   = !is_div ? 1'($urandom % 2) : (z > 0 && k == z);
    end
  endtask

  initial begin
    int s, z, f, junk;
    bit is_div, both;
    #7;
    chk_quiet("reset");
    chk("reset run_cycles", run_cycles, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op(0, 5, 0, 0, 0);
    run_op(1, 33 > SMAX ? SMAX : 33, 0, 0, 0);
    run_op(1, 3, 3, 0, 0);
    run_op(0, 6, 0, 1, 3);
    for (int i = 0; i < 25; i++) begin
      is_div = 1'($urandom % 2);
      s = $urandom_range(SMAX, 2);
      z = (is_div && $urandom % 2 == 1) ? $urandom_range(s, 1) : 0;
      both = !is_div && $urandom % 4 == 0;
      f = (z > 0 ? z : s) + 1;
      junk = ($urandom % 2 == 1) ? $urandom_range(f, 1) : 0;
      run_op(is_div, s, z, both, junk);
    end
    // asynchronous reset in the 4th MULT run cycle
    @(negedge clk);
    {mult_stop, div_stop, div_zero} = 3'b000;
    start_mult = 1'b1;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset busy", busy, 1);
    #2 reset = 1'b0;
    #1 chk_quiet("async reset");
    chk("async reset run_cycles", run_cycles, 0);
    @(negedge clk);
    reset = 1'b1;
    mult_stop = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_quiet("stop after reset");
    end
    mult_stop = 1'b0;
    // run that never receives a stop
    start_mult = 1'b1;
    @(negedge clk);
    start_mult = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      if (k == 8) chk("limit run_cycles", run_cycles, 7);
      chk("tmo timeout_err", timeout_err, k == 9);
      chk("tmo HiLo_load", HiLo_load, 0);
      chk("tmo busy", busy, k <= 9);
    end
`else
    repeat (99) @(negedge clk);
    chk("hang busy", busy, 1);
    chk("hang run_cycles", run_cycles, 99);
    repeat (35) @(negedge clk);
    chk("sat run_cycles", run_cycles, 127);
    chk("hang HiLo_load", HiLo_load, 0);
    chk("hang timeout_err", timeout_err, 0);
    reset = 1'b0;
    #1 chk_quiet("final reset");
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared multiplier/divider unit on behalf of the multicycle control unit.
- Accepts one-cycle start requests and issues the start pulses (mult_control / div_control).
- Waits for the unit's stop flag, then drives the Hi/Lo write-back selects and load strobe.
- Reports completion, divide-by-zero and misuse back to the control unit, which stalls on busy.

Parameters:
- TIMEOUT_CYCLES, 64, watchdog limit in run cycles (used only with MULDIV_TIMEOUT_EN).
- CNT_W, 7, width of run-cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start_mult  in  1  one-cycle request to start MULT.
- start_div  in  1  one-cycle request to start DIV.
- mult_stop  in  1  multiplier result valid.
- div_stop  in  1  divider result valid.
- div_zero  in  1  divider reports a zero divisor.
- mult_control  out  1  start pulse to the multiplier.
- div_control  out  1  start pulse to the divider.
- HiLo_load  out  1  Hi/Lo register write strobe.
- sel_mux_hi  out  1  Hi source: 0 = mult, 1 = div.
- sel_mux_lo  out  1  Lo source: 0 = mult, 1 = div.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- dp0_exc  out  1  one-cycle divide-by-zero exception pulse.
- req_err  out  1  one-cycle pulse for a dropped or illegal request.
- timeout_err  out  1  one-cycle watchdog pulse.
- run_cycles  out  CNT_W  cycles spent in the last or current run, saturating.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, every output 0, run_cycles 0. Reset asserted mid-run aborts the run; no HiLo_load is issued.
- All outputs are registered. States: IDLE, MULT_RUN, DIV_RUN, WB, EXC, TMO.
- IDLE:
  - busy=0.
  - start_mult=1 -> MULT_RUN; run_cycles cleared.
  - else start_div=1 -> DIV_RUN; run_cycles cleared.
  - start_mult and start_div together -> MULT wins; req_err pulses in that same next cycle.
- Entry to a RUN state:
  - The matching control pulse is high for exactly the first RUN cycle.
  - busy=1 from the first RUN cycle until the cycle after WB/EXC/TMO.
  - sel_mux_hi/lo are latched on entry: 0 for MULT, 1 for DIV, held through WB.
- MULT_RUN:
  - run_cycles += 1 per cycle, saturating at 2^CNT_W-1.
  - mult_stop is ignored in the first RUN cycle.
  - From the second cycle on, mult_stop=1 -> WB.
- DIV_RUN:
  - Same counting and stop-sampling rules, using div_stop.
  - div_zero=1 in any RUN cycle, including the first -> EXC.
  - div_zero has priority over a simultaneous div_stop.
- WB (one cycle): HiLo_load=1, done=1, then IDLE.
- EXC (one cycle): dp0_exc=1, HiLo_load=0, done=0, then IDLE.
- Latency: request sampled at edge T; control pulse in cycle T+1; stop first seen in cycle T+1+N (N>=1) -> HiLo_load/done in cycle T+2+N.
- Any start_* while busy=1 is dropped; req_err pulses the next cycle.
- A stop flag seen while IDLE is ignored.
- WB, EXC and TMO return to IDLE unconditionally. A start presented in a WB/EXC/TMO cycle is dropped with req_err.

Optional Feature:
- Macro MULDIV_TIMEOUT_EN.
- Defined:
  - In a RUN state, run_cycles reaching TIMEOUT_CYCLES-1 with no stop/zero in that cycle -> TMO.
  - TMO (one cycle): timeout_err=1, no HiLo_load, then IDLE.
  - A stop or zero flag in the limit cycle wins over the timeout.
- Undefined: no TMO state exists; timeout_err is tied to 0; a RUN state waits indefinitely.

Decomposition:
- Shared package: state encoding constants (3-bit), Hi/Lo select constants (SEL_MULT=0, SEL_DIV=1), default TIMEOUT_CYCLES.
- One natural sub-module, muldiv_run_counter: saturating counter with clear, enable and limit compare. It feeds run_cycles and the watchdog.

Test Plan:
- start_mult at T; mult_stop at T+5 -> mult_control high only in T+1; HiLo_load=done=1 in T+6 with sel_mux_hi/lo=0; run_cycles=5; busy low from T+7.
- start_div; div_stop after 33 cycles -> div_control single pulse; WB with sel_mux_hi/lo=1; run_cycles=33.
- start_div; div_zero and div_stop both high in the 3rd RUN cycle -> dp0_exc pulse; no HiLo_load or done; back to IDLE.
- start_mult and start_div in the same cycle; then start_div during the run -> MULT executes; req_err pulses twice; no div_control ever.
- reset driven low in the 4th cycle of MULT_RUN, asynchronously mid-cycle -> all outputs 0 immediately; a later mult_stop causes nothing.
- With MULDIV_TIMEOUT_EN and TIMEOUT_CYCLES=8, start_mult with no stop -> timeout_err in the cycle after run_cycles=7; no HiLo_load. Without the macro -> busy stays 1 after 100 cycles.
